// File: rtl/o_buf_ctrl_if.sv
// Bias stream, output-buffer port and drained-word stream seen by o_buf_ctrl.
// Signal names keep the controller's point of view (_i = into controller).
interface o_buf_ctrl_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] bias_data_i;
   logic             bias_valid_i;
   logic             bias_ready_o;
   logic             buf_wvalid_o;
   logic             buf_cw_o;
   logic [WIDTH-1:0] buf_cdata_o;
   logic [AW-1:0]    buf_raddr_o;
   logic [WIDTH-1:0] buf_rdata_i;
   logic [WIDTH-1:0] out_data_o;
   logic             out_valid_o;
   logic             out_ready_i;

   modport master (
      input  bias_data_i, bias_valid_i, buf_rdata_i, out_ready_i,
      output bias_ready_o, buf_wvalid_o, buf_cw_o, buf_cdata_o, buf_raddr_o,
             out_data_o, out_valid_o
   );

   modport slave (
      output bias_data_i, bias_valid_i, buf_rdata_i, out_ready_i,
      input  bias_ready_o, buf_wvalid_o, buf_cw_o, buf_cdata_o, buf_raddr_o,
             out_data_o, out_valid_o
   );
endinterface

// File: rtl/o_buf_ctrl.sv
// Output-buffer controller: initialise entries, count accumulate passes, drain entries.
// Define O_BUF_CTRL_BIAS_EN to load entries from the bias stream instead of zeros.
module o_buf_ctrl #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 8,
   parameter int PASS_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic [PASS_W-1:0] npass_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   input  logic              acc_valid_i,
   o_buf_ctrl_if.master      bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0]     A_ZERO = {AW{1'b0}};
   localparam logic [AW-1:0]     A_ONE  = AW'(1);
   localparam logic [AW-1:0]     A_LAST = AW'(DEPTH - 1);
   localparam logic [PASS_W-1:0] P_ZERO = {PASS_W{1'b0}};
   localparam logic [PASS_W-1:0] P_ONE  = PASS_W'(1);
   localparam logic [WIDTH-1:0]  D_ZERO = {WIDTH{1'b0}};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_INIT      = 3'd1,
      S_ACCUM     = 3'd2,
      S_DRAIN_RD  = 3'd3,
      S_DRAIN_OUT = 3'd4,
      S_DONE      = 3'd5
   } state_t;

   state_t            state_r, state_s;
   logic [AW-1:0]     idx_r, idx_s;
   logic [PASS_W-1:0] pass_r, pass_s;
   logic [PASS_W-1:0] npass_r, npass_s;
   logic              busy_r, done_r, err_r;
   logic              err_s, err_set_s, err_clr_s;
   logic              init_wr_s, bias_err_s, busy_s;
   logic [WIDTH-1:0]  cdata_s;

`ifdef O_BUF_CTRL_BIAS_EN
   assign init_wr_s          = (state_r == S_INIT) && bus.bias_valid_i;
   assign bias_err_s         = bus.bias_valid_i && (state_r != S_INIT);
   assign cdata_s            = init_wr_s ? bus.bias_data_i : D_ZERO;
   assign bus.bias_ready_o   = (state_r == S_INIT);
`else
   assign init_wr_s          = (state_r == S_INIT);
   assign bias_err_s         = 1'b0;
   assign cdata_s            = D_ZERO;
   assign bus.bias_ready_o   = 1'b0;
`endif

   // Single index walks init writes, mirrors the buffer write pointer, then drains.
   always_comb begin
      state_s = state_r;
      idx_s   = idx_r;
      pass_s  = pass_r;
      npass_s = npass_r;
      case (state_r)
         S_IDLE: begin
            if (start_i) begin
               npass_s = npass_i;
               idx_s   = A_ZERO;
               pass_s  = P_ZERO;
               state_s = S_INIT;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_INIT: begin
            if (init_wr_s && (idx_r == A_LAST)) begin
               idx_s   = A_ZERO;
               state_s = (npass_r == P_ZERO) ? S_DRAIN_RD : S_ACCUM;
            end else if (init_wr_s) begin
               idx_s = idx_r + A_ONE;
            end else begin
               idx_s = idx_r;
            end
         end
         S_ACCUM: begin
            if (acc_valid_i) begin
               idx_s = idx_r + A_ONE;
               if ((idx_r == A_LAST) && (pass_r == (npass_r - P_ONE))) begin
                  pass_s  = P_ZERO;
                  state_s = S_DRAIN_RD;
               end else if (idx_r == A_LAST) begin
                  pass_s = pass_r + P_ONE;
               end else begin
                  pass_s = pass_r;
               end
            end else begin
               idx_s = idx_r;
            end
         end
         S_DRAIN_RD: begin
            state_s = S_DRAIN_OUT;
         end
         S_DRAIN_OUT: begin
            if (bus.out_ready_i && (idx_r == A_LAST)) begin
               idx_s   = A_ZERO;
               state_s = S_DONE;
            end else if (bus.out_ready_i) begin
               idx_s   = idx_r + A_ONE;
               state_s = S_DRAIN_RD;
            end else begin
               state_s = S_DRAIN_OUT;
            end
         end
         S_DONE: begin
            state_s = S_IDLE;
         end
         default: begin
            state_s = S_IDLE;
            idx_s   = A_ZERO;
            pass_s  = P_ZERO;
         end
      endcase
   end

   // A new error in the start cycle still wins over the clear.
   assign err_clr_s = (state_r == S_IDLE) && start_i;
   assign err_set_s = (acc_valid_i && (state_r != S_ACCUM)) || bias_err_s;
   assign err_s     = err_set_s | (err_r & ~err_clr_s);
   assign busy_s    = (state_s == S_INIT) || (state_s == S_ACCUM) ||
                      (state_s == S_DRAIN_RD) || (state_s == S_DRAIN_OUT);

   // State, counters and status flags.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_r <= S_IDLE;
         idx_r   <= A_ZERO;
         pass_r  <= P_ZERO;
         npass_r <= P_ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_s;
         idx_r   <= idx_s;
         pass_r  <= pass_s;
         npass_r <= npass_s;
         busy_r  <= busy_s;
         done_r  <= (state_s == S_DONE);
         err_r   <= err_s;
      end
   end

   assign busy_o           = busy_r;
   assign done_o           = done_r;
   assign err_o            = err_r;
   assign bus.buf_wvalid_o = (state_r == S_ACCUM) ? acc_valid_i : 1'b0;
   assign bus.buf_cw_o     = init_wr_s;
   assign bus.buf_cdata_o  = cdata_s;
   assign bus.buf_raddr_o  = idx_r;
   assign bus.out_valid_o  = (state_r == S_DRAIN_OUT);
   assign bus.out_data_o   = (state_r == S_DRAIN_OUT) ? bus.buf_rdata_i : D_ZERO;
endmodule
